// File: rtl/uart_coe_loader.sv
// UART program loader: receives 8N1 bytes, packs them little-endian into 32-bit words
// and strobes them into instruction memory, then data memory, reporting busy/done/error.
module uart_coe_loader #(
  parameter int CLKS_PER_BIT   = 87,
  parameter int ADDR_WIDTH     = 14,
  parameter int IM_WORDS       = 16384,
  parameter int DM_WORDS       = 16384,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  iUpgClock,
  input  logic                  iUpgReset,
  input  logic                  iStartReceiveCoe,
  input  logic                  iUartFromPc,
  output logic                  oWriteEnable,
  output logic                  oWriteToData,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [31:0]           oWriteData,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oError
);

  localparam int BIT_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TO_CW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BIT_CW-1:0]     BIT_LAST  = BIT_CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CW-1:0]     HALF_LAST = BIT_CW'((CLKS_PER_BIT / 2) - 1);
  localparam logic [TO_CW-1:0]      TO_LAST   = TO_CW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] IM_LAST   = ADDR_WIDTH'(IM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] DM_LAST   = ADDR_WIDTH'(DM_WORDS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {IDLE, LOAD_IM, LOAD_DM, DONE} loadState_t;

  rxState_t           rxState;
  logic               rxMeta;
  logic               rxSync;
  logic [BIT_CW-1:0]  bitTimer;
  logic [2:0]         bitIndex;
  logic [7:0]         rxByte;
  logic               byteValid;
  logic               frameError;

  loadState_t         loadState;
  logic               startQ;
  logic               startRise;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]         lane;
  logic [23:0]        partialWord;
  logic [TO_CW-1:0]   timeoutCount;
  logic               seenByte;

  assign startRise = iStartReceiveCoe & ~startQ;

  // The synchroniser flops reset to the idle-high level so reset never looks like a start bit.
  always_ff @(posedge iUpgClock) begin
    if (iUpgReset) begin
      rxMeta     <= 1'b1;
      rxSync     <= 1'b1;
      rxState    <= RX_IDLE;
      bitTimer   <= '0;
      bitIndex   <= '0;
      rxByte     <= '0;
      byteValid  <= 1'b0;
      frameError <= 1'b0;
    end else begin
      rxMeta     <= iUartFromPc;
      rxSync     <= rxMeta;
      byteValid  <= 1'b0;
      frameError <= 1'b0;
      case (rxState)
        RX_IDLE: begin
          bitTimer <= '0;
          bitIndex <= '0;
          if (!rxSync) rxState <= RX_START;
        end
        RX_START: begin
          if (bitTimer == HALF_LAST) begin
            bitTimer <= '0;
            rxState  <= rxSync ? RX_IDLE : RX_DATA;
          end else begin
            bitTimer <= bitTimer + 1'b1;
          end
        end
        RX_DATA: begin
          if (bitTimer == BIT_LAST) begin
            bitTimer <= '0;
            rxByte   <= {rxSync, rxByte[7:1]};
            bitIndex <= bitIndex + 1'b1;
            if (bitIndex == 3'd7) rxState <= RX_STOP;
          end else begin
            bitTimer <= bitTimer + 1'b1;
          end
        end
        RX_STOP: begin
          if (bitTimer == BIT_LAST) begin
            bitTimer <= '0;
            rxState  <= RX_IDLE;
            if (rxSync) byteValid  <= 1'b1;
            else        frameError <= 1'b1;
          end else begin
            bitTimer <= bitTimer + 1'b1;
          end
        end
        default: rxState <= RX_IDLE;
      endcase
    end
  end

  // The fourth byte of a word is merged straight into the strobe so the write lands one cycle after it.
  always_ff @(posedge iUpgClock) begin
    if (iUpgReset) begin
      startQ        <= 1'b0;
      loadState     <= IDLE;
      addr          <= '0;
      lane          <= '0;
      partialWord   <= '0;
      timeoutCount  <= '0;
      seenByte      <= 1'b0;
      oWriteEnable  <= 1'b0;
      oWriteToData  <= 1'b0;
      oWriteAddress <= '0;
      oWriteData    <= '0;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
      oError        <= 1'b0;
    end else begin
      startQ       <= iStartReceiveCoe;
      oWriteEnable <= 1'b0;
      case (loadState)
        IDLE, DONE: begin
          if (startRise) begin
            loadState    <= LOAD_IM;
            addr         <= '0;
            lane         <= '0;
            timeoutCount <= '0;
            seenByte     <= 1'b0;
            oError       <= 1'b0;
            oDone        <= 1'b0;
            oBusy        <= 1'b1;
          end
        end
        LOAD_IM, LOAD_DM: begin
          if (frameError) oError <= 1'b1;
          if (byteValid) begin
            seenByte     <= 1'b1;
            timeoutCount <= '0;
            if (lane == 2'd3) begin
              oWriteEnable  <= 1'b1;
              oWriteData    <= {rxByte, partialWord};
              oWriteAddress <= addr;
              oWriteToData  <= (loadState == LOAD_DM);
              lane          <= '0;
              if (loadState == LOAD_IM && addr == IM_LAST) begin
                loadState <= LOAD_DM;
                addr      <= '0;
              end else if (loadState == LOAD_DM && addr == DM_LAST) begin
                loadState <= DONE;
                oBusy     <= 1'b0;
                oDone     <= 1'b1;
              end else begin
                addr <= addr + 1'b1;
              end
            end else begin
              case (lane)
                2'd0:    partialWord[7:0]   <= rxByte;
                2'd1:    partialWord[15:8]  <= rxByte;
                default: partialWord[23:16] <= rxByte;
              endcase
              lane <= lane + 1'b1;
            end
          end else if (seenByte) begin
            if (timeoutCount == TO_LAST) begin
              loadState <= DONE;
              lane      <= '0;
              oBusy     <= 1'b0;
              oDone     <= 1'b1;
              oError    <= 1'b1;
            end else begin
              timeoutCount <= timeoutCount + 1'b1;
            end
          end
        end
        default: loadState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_coe_loader.sv
// Scoreboarded bench for uart_coe_loader: random serial bytes feed a word-level
// reference model whose expected writes are checked by an independent strobe monitor.
module tb_uart_coe_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;
  localparam int IMW = 2;
  localparam int DMW = 2;
  localparam int TO  = 200;

  typedef struct packed {
    logic          toData;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } expWord_t;

  logic          clock;
  logic          reset;
  logic          startReq;
  logic          rxLine;
  logic          writeEnable;
  logic          writeToData;
  logic [AW-1:0] writeAddress;
  logic [31:0]   writeData;
  logic          busy;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;

  expWord_t  expQ[$];
  logic [7:0] partial[$];
  bit        modelLoading = 0;
  int        modelBank    = 0;
  int        modelAddr    = 0;
  bit        prevWe       = 0;

  uart_coe_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .IM_WORDS(IMW),
    .DM_WORDS(DMW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .iUpgClock(clock),
    .iUpgReset(reset),
    .iStartReceiveCoe(startReq),
    .iUartFromPc(rxLine),
    .oWriteEnable(writeEnable),
    .oWriteToData(writeToData),
    .oWriteAddress(writeAddress),
    .oWriteData(writeData),
    .oBusy(busy),
    .oDone(done),
    .oError(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  // Reference model: bytes accumulate into words; words fill IM then DM.
  task automatic modelByte(input logic [7:0] b, input bit good);
    expWord_t e;
    if (!modelLoading || !good) return;
    partial.push_back(b);
    if (partial.size() == 4) begin
      e.toData = (modelBank == 1);
      e.addr   = AW'(modelAddr);
      e.data   = {partial[3], partial[2], partial[1], partial[0]};
      expQ.push_back(e);
      partial.delete();
      modelAddr++;
      if (modelBank == 0 && modelAddr == IMW) begin
        modelBank = 1;
        modelAddr = 0;
      end else if (modelBank == 1 && modelAddr == DMW) begin
        modelLoading = 0;
      end
    end
  endtask

  task automatic driveSerial(input logic [7:0] b, input logic stopBit);
    @(negedge clock);
    rxLine = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxLine = b[i];
      repeat (CPB) @(negedge clock);
    end
    rxLine = stopBit;
    repeat (CPB) @(negedge clock);
    rxLine = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit good);
    modelByte(b, good);
    driveSerial(b, good);
    repeat (8 + $urandom_range(0, 12)) @(negedge clock);
  endtask

  task automatic startLoad();
    if (!modelLoading) begin
      modelLoading = 1;
      modelBank    = 0;
      modelAddr    = 0;
      partial.delete();
    end
    @(negedge clock);
    startReq = 1'b1;
    repeat (2) @(negedge clock);
    startReq = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " we"},   writeEnable,  0);
    checkOutput({tag, " toD"},  writeToData,  0);
    checkOutput({tag, " addr"}, writeAddress, 0);
    checkOutput({tag, " data"}, writeData,    0);
    checkOutput({tag, " busy"}, busy,         0);
    checkOutput({tag, " done"}, done,         0);
    checkOutput({tag, " err"},  error,        0);
  endtask

  // Monitor: every strobe must match the oldest expected word and last exactly one cycle.
  always @(negedge clock) begin
    if (!reset && writeEnable) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected strobe: got toD=%0d addr=%0h data=%h want none",
                 writeToData, writeAddress, writeData);
      end else begin
        expWord_t e;
        e = expQ.pop_front();
        if (writeToData !== e.toData || writeAddress !== e.addr || writeData !== e.data) begin
          bad++;
          $display("[TB] FAIL strobe: got toD=%0d addr=%0h data=%h want toD=%0d addr=%0h data=%h",
                   writeToData, writeAddress, writeData, e.toData, e.addr, e.data);
        end
      end
      if (prevWe) begin
        bad++;
        $display("[TB] FAIL strobe width: got 2+ cycles want 1");
      end
    end
    prevWe = writeEnable;
  end

  initial begin
    logic [7:0] fixedBytes [8];
    fixedBytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    reset    = 1'b1;
    rxLine   = 1'b1;
    startReq = 1'b0;
    repeat (3) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Fixed first image words
    startLoad();
    checkOutput("t1 busy", busy, 1);
    checkOutput("t1 done", done, 0);
    foreach (fixedBytes[i]) applyStimulus(fixedBytes[i], 1);
    checkOutput("t1 busy after IM", busy, 1);

    // DM fill, then extra bytes after DONE are dropped
    for (int i = 0; i < 16; i++) applyStimulus(8'($urandom), 1);
    checkOutput("t2 done", done, 1);
    checkOutput("t2 busy", busy, 0);
    checkOutput("t2 err", error, 0);
    applyStimulus(8'($urandom), 1);
    checkOutput("t2 done hold", done, 1);

    // Framing error during LOAD_IM
    startLoad();
    checkOutput("t3 done cleared", done, 0);
    checkOutput("t3 err cleared", error, 0);
    applyStimulus(8'($urandom), 0);
    checkOutput("t3 err", error, 1);
    for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 1);
    checkOutput("t3 busy", busy, 1);

    // Timeout with a partial word pending
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 1);
    repeat (150) @(negedge clock);
    checkOutput("t4 busy before timeout", busy, 1);
    repeat (70) @(negedge clock);
    modelLoading = 0;
    partial.delete();
    checkOutput("t4 done", done, 1);
    checkOutput("t4 err", error, 1);
    checkOutput("t4 busy", busy, 0);

    // Reset in the middle of the second byte of a load
    startLoad();
    checkOutput("t5 err cleared", error, 0);
    applyStimulus(8'($urandom), 1);
    fork
      driveSerial(8'($urandom), 1'b1);
      begin
        repeat (CPB * 5) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkAllZero("t5 reset");
        @(negedge clock);
        reset = 1'b0;
      end
    join
    modelLoading = 0;
    partial.delete();
    repeat (60) @(negedge clock);
    checkOutput("t5 idle busy", busy, 0);
    startLoad();
    for (int i = 0; i < 8; i++) applyStimulus(8'($urandom), 1);
    checkOutput("t5 busy in DM", busy, 1);

    // RX glitch, then a start rise inside LOAD_DM
    @(negedge clock);
    rxLine = 1'b0;
    @(negedge clock);
    rxLine = 1'b1;
    repeat (10) @(negedge clock);
    checkOutput("t6 glitch err", error, 0);
    checkOutput("t6 glitch busy", busy, 1);
    startLoad();
    for (int i = 0; i < 8; i++) applyStimulus(8'($urandom), 1);
    checkOutput("t6 done", done, 1);
    checkOutput("t6 err", error, 0);
    checkOutput("t6 busy", busy, 0);

    repeat (20) @(negedge clock);
    checkOutput("leftover expected", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
